// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up-counter with a time-multiplexed digit scanner feeding one shared
// seven-segment decoder: one registered nibble and a one-hot digit select per cycle.
module bcd_scan_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter bit          LZB      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  clr,
  input  logic                  hold,
  output logic [4*DIGITS-1:0]   value,
  output logic                  overflow,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PreW = $clog2(SCAN_DIV);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [PreW-1:0]     presc_q, presc_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [3:0]          bcd_q, bcd_d;
  logic [DIGITS-1:0]   en_q, en_d;

  logic       carry;
  logic [3:0] nib;
  logic       presc_wrap;
  logic       upper_zero;
  logic       blank;

  // Count: clr beats hold beats inc; a held inc is dropped, not queued.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    carry   = 1'b0;
    nib     = 4'd0;
    if (clr) begin
      count_d = '0;
    end else if (!hold && inc) begin
      carry = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        nib = count_q[4*k +: 4];
        if (carry) begin
          if (nib == 4'd9) begin
            count_d[4*k +: 4] = 4'd0;
          end else begin
            count_d[4*k +: 4] = nib + 4'd1;
            carry             = 1'b0;
          end
        end
      end
      ovf_d = carry;
    end
  end

  // Scanner runs freely; no count command touches it.
  always_comb begin
    presc_wrap = (presc_q == PreW'(SCAN_DIV - 1));
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    if (presc_wrap) begin
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Blank a slot only when it and every more-significant digit are zero.
  always_comb begin
    bcd_d      = 4'd0;
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (IdxW'(k) == idx_q) begin
        bcd_d = count_q[4*k +: 4];
      end
      if ((IdxW'(k) >= idx_q) && (count_q[4*k +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    blank = LZB && (idx_q != '0) && upper_zero;
    en_d  = blank ? '0 : (DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      bcd_q   <= 4'd0;
      en_q    <= '0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      bcd_q   <= bcd_d;
      en_q    <= en_d;
    end
  end

  assign value    = count_q;
  assign overflow = ovf_q;
  assign bcd_out  = bcd_q;
  assign digit_en = en_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: an integer count and cycle-indexed scan model, checked
// against two instances that differ only in leading-zero blanking.
module tb_bcd_scan_counter;

  localparam int ND = 4;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inc = 1'b0, clr = 1'b0, hold = 1'b0;

  logic [4*ND-1:0] value1, value0;
  logic            ovf1, ovf0;
  logic [3:0]      bcd1, bcd0;
  logic [ND-1:0]   en1, en0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int         m_count;
  logic       m_ovf;
  int         m_cyc;
  logic [3:0] m_bcd;
  logic [3:0] m_en1, m_en0;

  always #5 clk = ~clk;

  bcd_scan_counter #(.DIGITS(ND), .SCAN_DIV(SD), .LZB(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr), .hold(hold),
    .value(value1), .overflow(ovf1), .bcd_out(bcd1), .digit_en(en1)
  );

  bcd_scan_counter #(.DIGITS(ND), .SCAN_DIV(SD), .LZB(1'b0)) u_dut_nz (
    .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr), .hold(hold),
    .value(value0), .overflow(ovf0), .bcd_out(bcd0), .digit_en(en0)
  );

  function automatic int p10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t = v;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [33:0] obs_vec();
    return {value1, ovf1, bcd1, en1, bcd0, en0};
  endfunction

  function automatic logic [33:0] exp_vec();
    return {to_bcd(m_count), m_ovf, m_bcd, m_en1, m_bcd, m_en0};
  endfunction

  task automatic model_reset();
    m_count = 0;
    m_ovf   = 1'b0;
    m_cyc   = 0;
    m_bcd   = 4'd0;
    m_en1   = 4'd0;
    m_en0   = 4'd0;
  endtask

  // Drive one cycle and advance the model; outputs are sampled 1 time unit after the edge.
  task automatic step(input bit i, input bit c, input bit h);
    int idx;
    inc  = i;
    clr  = c;
    hold = h;
    idx   = (m_cyc / SD) % ND;
    m_bcd = 4'((m_count / p10(idx)) % 10);
    m_en0 = 4'b1 << idx;
    m_en1 = (idx > 0 && (m_count / p10(idx)) == 0) ? 4'b0 : (4'b1 << idx);
    m_ovf = 1'b0;
    if (c) begin
      m_count = 0;
    end else if (!h && i) begin
      m_ovf   = (m_count == p10(ND) - 1);
      m_count = (m_count + 1) % p10(ND);
    end
    @(posedge clk);
    #1;
    m_cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({value1, ovf1, bcd1, en1, en0} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {value1, ovf1, bcd1, en1, en0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step(0, 0, 0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got %h required %h", c, obs_vec(), exp_vec());
      end
      if (c == 1 || c == SD + 1) begin
        n_checks++;
        if (en1 !== ((c == 1) ? 4'b0001 : 4'b0000)) begin
          n_fail++;
          $display("FAIL idle_slot_en%0d: got %b", c, en1);
        end
      end
    end
  endtask

  task automatic test_count12();
    for (int n = 0; n < 12; n++) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
    n_checks++;
    if (value1 !== 16'h0012) begin
      n_fail++;
      $display("FAIL count12_value: got %h required 0012", value1);
    end
    for (int c = 0; c < 2 * ND * SD; c++) begin
      step(0, 0, 0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL count12_frame%0d: got %h required %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    step(0, 1, 0);
    repeat (9999) step(1, 0, 0);
    step(0, 0, 0);
    n_checks++;
    if ({value1, ovf1} !== {16'h9999, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_preload: got %h/%b required 9999/0", value1, ovf1);
    end
    step(1, 0, 0);
    n_checks++;
    if ({value1, ovf1, ovf0} !== {16'h0000, 2'b11}) begin
      n_fail++;
      $display("FAIL wrap_pulse: got %h/%b%b required 0000/11", value1, ovf1, ovf0);
    end
    step(0, 0, 0);
    n_checks++;
    if (ovf1 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_pulse_width: got %b required 0", ovf1);
    end
    step(1, 0, 0);
    n_checks++;
    if ({value1, ovf1} !== {16'h0001, 1'b0} || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL wrap_second_inc: got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_hold_clr();
    step(0, 1, 0);
    repeat (7) step(1, 0, 0);
    for (int c = 0; c < 5; c++) begin
      step(1, 0, 1);
      n_checks++;
      if (value1 !== 16'h0007) begin
        n_fail++;
        $display("FAIL hold_value%0d: got %h required 0007", c, value1);
      end
    end
    step(1, 1, 1);
    n_checks++;
    if ({value1, ovf1} !== 17'd0) begin
      n_fail++;
      $display("FAIL clr_priority: got %h/%b required 0000/0", value1, ovf1);
    end
  endtask

  task automatic test_embedded_zero();
    bit         saw_slot1;
    logic [3:0] or_en1, or_en0;
    step(0, 1, 0);
    repeat (109) step(1, 0, 0);
    n_checks++;
    if (value1 !== 16'h0109) begin
      n_fail++;
      $display("FAIL hold109_value: got %h required 0109", value1);
    end
    saw_slot1 = 1'b0;
    for (int c = 0; c < ND * SD + 2; c++) begin
      step(0, 0, 0);
      if (en1 === 4'b0010 && bcd1 === 4'd0) saw_slot1 = 1'b1;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL hold109_frame%0d: got %h required %h", c, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (saw_slot1 !== 1'b1) begin
      n_fail++;
      $display("FAIL embedded_zero_slot: got %b required 1", saw_slot1);
    end
    step(0, 1, 0);
    repeat (3) step(1, 0, 0);
    or_en1 = 4'd0;
    or_en0 = 4'd0;
    for (int c = 0; c < ND * SD + 2; c++) begin
      step(0, 0, 0);
      or_en1 |= en1;
      or_en0 |= en0;
    end
    n_checks++;
    if ({or_en0, or_en1} !== {4'b1111, 4'b0001}) begin
      n_fail++;
      $display("FAIL lzb_slots: got %b/%b required 1111/0001", or_en0, or_en1);
    end
  endtask

  task automatic test_random();
    bit i, c, h;
    for (int n = 0; n < 400; n++) begin
      i = 1'($urandom % 2);
      c = ($urandom % 16) == 0;
      h = ($urandom % 5) == 0;
      step(i, c, h);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random%0d: got %h required %h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    step(0, 1, 0);
    repeat (456) step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    n_checks++;
    if (value1 !== 16'h0456) begin
      n_fail++;
      $display("FAIL async_preload: got %h required 0456", value1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({value1, ovf1, bcd1, en1, value0, bcd0, en0} !== 49'd0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %h required 0",
               {value1, ovf1, bcd1, en1, value0, bcd0, en0});
    end
    model_reset();
    #2;
    rst_n = 1'b1;
    for (int c = 1; c <= SD + 1; c++) begin
      step(0, 0, 0);
      n_checks++;
      if (en0 !== ((c <= SD) ? 4'b0001 : 4'b0010) || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL async_rescan%0d: got %h required %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_count12();
    test_wrap();
    test_hold_clr();
    test_embedded_zero();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
